fir_uart_ctrl: RTL and testbench
================================

# fir_uart_ctrl

Frame controller between the 16-bit UART word assembler and the FIR filter core. Consumes the assembled word stream (`dataout`/`o_datavalid` of the word assembler) and parses sync/header framed packets. Depending on the command it writes filter coefficients, forwards samples to the FIR input through a one-entry valid/ready holding register, or pulses a filter-state clear. Errors are flagged and the controller resynchronises on an inter-word timeout.

## Interface
- `NUM_TAPS`, 16: coefficient memory depth; maximum load length.
- `ADDR_W`, 4: coefficient address width; must satisfy 2^ADDR_W >= NUM_TAPS.
- `TIMEOUT_CLKS`, 50000: maximum idle clocks between words inside a frame (about 2 word times at 1250 clocks/bit).
- `SYNC_WORD`, 16'hA55A: frame start marker.
- `i_clk` in 1: system clock.
- `i_rstn` in 1: reset, asynchronous, active-low.
- `i_word` in 16: assembled UART word.
- `i_wordval` in 1: one-cycle strobe; `i_word` is valid.
- `o_coef_we` in/out: out 1: coefficient write strobe.
- `o_coef_addr` out ADDR_W: coefficient write address.
- `o_coef_data` out 16: coefficient write data.
- `o_sample` out 16: sample to FIR.
- `o_sample_val` out 1: sample valid.
- `i_sample_rdy` in 1: FIR accepts sample.
- `o_fir_clr` out 1: one-cycle FIR delay-line clear.
- `o_frame_done` out 1: one-cycle strobe; frame completed without error.
- `o_busy` out 1: state is not IDLE, or a sample is pending.
- `o_err_timeout`, `o_err_overflow`, `o_err_cmd` out 1 each: sticky error flags.

## Operation
- Header word layout: [15:12] cmd, [11:0] len. Commands:
  - 1 = LOAD
  - 2 = STREAM
  - 3 = CLEAR
  - any other value is illegal.
- States: IDLE, HDR, LOAD, STREAM.
- IDLE:
  - Non-sync words are ignored.
  - `i_word == SYNC_WORD` moves to HDR and clears all three error flags.
- HDR (next word is the header):
  - LOAD with 1 <= len <= NUM_TAPS: go to LOAD, word count = 0.
  - STREAM with len >= 1: go to STREAM.
  - STREAM with len == 0: pulse `o_frame_done`, go to IDLE.
  - CLEAR: pulse `o_fir_clr` and `o_frame_done`, go to IDLE. len is ignored.
  - Illegal cmd, LOAD with len == 0, or LOAD with len > NUM_TAPS: set `o_err_cmd`, go to IDLE. No writes occur.
- LOAD: each word writes address = count, data = word; count increments. After the len-th word: pulse `o_frame_done`, go to IDLE.
- STREAM: each word goes to the holding register.
  - If the register is empty, or is being emptied in the same cycle (`o_sample_val && i_sample_rdy`), the word is accepted.
  - Otherwise the word is dropped and `o_err_overflow` is set.
  - Dropped words still count toward len, so framing is preserved.
  - After the len-th word: pulse `o_frame_done` unless overflow occurred in this frame; go to IDLE.
- Timeout:
  - The counter resets on every `i_wordval` and does not count in IDLE.
  - In HDR, LOAD or STREAM, reaching TIMEOUT_CLKS-1 idle clocks sets `o_err_timeout` and returns to IDLE.
  - Partial LOAD writes are not rolled back.
- Holding register:
  - Once `o_sample_val` is asserted it holds, with `o_sample` stable, until `i_sample_rdy`.
  - A pending sample is never dropped by a timeout, an error, or a new SYNC.
- Arithmetic: count is 12 bits; frame end is `count == len-1` at the word strobe. No wrap-around is possible.

## Timing
- Reset: all outputs 0, state IDLE, holding register empty, counters 0.
- All outputs are registered:
  - `o_coef_we`, `o_fir_clr` and `o_frame_done` assert the cycle after the causing `i_wordval`.
  - `o_sample_val` rises the cycle after acceptance.
  - A sample is consumed on the clock edge where `o_sample_val && i_sample_rdy`; `o_sample_val` deasserts next cycle unless refilled on that same edge.
- `o_coef_we`, `o_fir_clr` and `o_frame_done` are single-cycle pulses.
- Back-to-back `i_wordval` on consecutive cycles is supported in every state.
- Timeout and `i_wordval` in the same cycle: the word wins and the timeout does not fire.
- Asynchronous reset mid-frame returns to the reset state immediately; any pending sample is discarded.

## Structure
- Package `fir_uart_pkg`:
  - cmd code constants (LOAD/STREAM/CLEAR)
  - SYNC_WORD default
  - state enum
  - header field bit positions
- Sub-module `fir_ctrl_timeout`: a loadable down-counter with clear on `i_wordval`, enable when not IDLE, and a one-cycle expiry pulse.
- The FSM, count and holding register stay in the top level.

## Test plan
- Load: A55A, 1004, 0011, 0022, 0033, 0044 -> writes addr0..3 = 0011/0022/0033/0044, one `o_frame_done` pulse, errors 0.
- Stream with backpressure: A55A, 2003, 0100, 0200, 0300 with `i_sample_rdy` held low until after the 3rd word:
  - 0100 is held on `o_sample`.
  - 0200 and 0300 are dropped and `o_err_overflow`=1.
  - No `o_frame_done`.
  - Raising rdy delivers exactly 0100.
- Stream, same-cycle pop and push: rdy high, words on consecutive cycles -> all delivered in order, no overflow.
- Illegal header: A55A, 7000 -> `o_err_cmd`=1, no writes. A following A55A clears the flag.
- Oversized load: A55A, 1011 with NUM_TAPS=16 -> `o_err_cmd`=1, no writes.
- Timeout: A55A, 1004, 0011, then silence for TIMEOUT_CLKS -> `o_err_timeout`=1, state IDLE, only addr0 written. A subsequent valid CLEAR frame pulses `o_fir_clr` and clears the flag.

Source files
------------

// File: rtl/fir_uart_pkg.sv
// Shared definitions for the UART frame controller: command codes, sync marker,
// FSM state encoding and header field positions.
package fir_uart_pkg;

    localparam logic [15:0] SYNC_WORD_DEF = 16'hA55A;

    localparam logic [3:0] CMD_LOAD   = 4'd1;
    localparam logic [3:0] CMD_STREAM = 4'd2;
    localparam logic [3:0] CMD_CLEAR  = 4'd3;

    localparam int unsigned HDR_CMD_MSB = 15;
    localparam int unsigned HDR_CMD_LSB = 12;
    localparam int unsigned HDR_LEN_MSB = 11;
    localparam int unsigned HDR_LEN_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_LOAD,
        ST_STREAM
    } state_t;

    function automatic logic [3:0] hdr_cmd(input logic [15:0] w);
        return w[HDR_CMD_MSB:HDR_CMD_LSB];
    endfunction

    function automatic logic [11:0] hdr_len(input logic [15:0] w);
        return w[HDR_LEN_MSB:HDR_LEN_LSB];
    endfunction

endpackage

// File: rtl/fir_uart_ctrl_if.sv
// Word input, coefficient write port and sample valid/ready handshake of the
// frame controller. The master modport is the controller side.
interface fir_uart_ctrl_if #(
    parameter int unsigned ADDR_W = 4
);
    logic [15:0]       i_word;
    logic              i_wordval;
    logic              o_coef_we;
    logic [ADDR_W-1:0] o_coef_addr;
    logic [15:0]       o_coef_data;
    logic [15:0]       o_sample;
    logic              o_sample_val;
    logic              i_sample_rdy;

    modport master (
        input  i_word, i_wordval, i_sample_rdy,
        output o_coef_we, o_coef_addr, o_coef_data, o_sample, o_sample_val
    );

    modport slave (
        output i_word, i_wordval, i_sample_rdy,
        input  o_coef_we, o_coef_addr, o_coef_data, o_sample, o_sample_val
    );
endinterface

// File: rtl/fir_ctrl_timeout.sv
// Inter-word timeout: down-counter reloaded on every word strobe and while
// disabled; expiry is flagged when it has run down to zero with no word arriving.
module fir_ctrl_timeout #(
    parameter int unsigned TIMEOUT_CLKS = 50000
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    localparam int unsigned     CW       = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CW-1:0]   LOAD_VAL = CW'(TIMEOUT_CLKS - 1);

    logic [CW-1:0] r_cnt;

    // Reload on word or when idle, otherwise count down and stop at zero.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_cnt <= '0;
        end else if (i_clr || !i_en) begin
            r_cnt <= LOAD_VAL;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // A word in the same cycle suppresses expiry; the FSM leaving its active
    // states drops i_en, so the pulse lasts one cycle.
    always_comb begin
        o_expire = i_en && !i_clr && (r_cnt == '0);
    end
endmodule

// File: rtl/fir_uart_ctrl.sv
// Frame controller between the UART word assembler and the FIR core: parses
// sync/header frames, writes coefficients, forwards samples through a one-entry
// holding register and pulses the FIR clear.
module fir_uart_ctrl
    import fir_uart_pkg::*;
#(
    parameter int unsigned NUM_TAPS     = 16,
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned TIMEOUT_CLKS = 50000,
    parameter logic [15:0] SYNC_WORD    = SYNC_WORD_DEF
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    fir_uart_ctrl_if.master bus,
    output logic            o_fir_clr,
    output logic            o_frame_done,
    output logic            o_busy,
    output logic            o_err_timeout,
    output logic            o_err_overflow,
    output logic            o_err_cmd
);
    state_t            r_state;
    state_t            w_state_nxt;
    logic [11:0]       r_count;
    logic [11:0]       r_len;
    logic [15:0]       r_sample;
    logic              r_sample_val;
    logic              r_ovf_frame;
    logic              r_coef_we;
    logic [ADDR_W-1:0] r_coef_addr;
    logic [15:0]       r_coef_data;
    logic              r_fir_clr;
    logic              r_frame_done;
    logic              r_err_tmo;
    logic              r_err_ovf;
    logic              r_err_cmd;

    logic [15:0]       w_word;
    logic              w_wordval;
    logic [3:0]        w_hdr_cmd;
    logic [11:0]       w_hdr_len;
    logic              w_load_len_ok;
    logic              w_last;
    logic              w_pop;
    logic              w_tmo_en;
    logic              w_expire;
    logic              w_coef_we;
    logic              w_fir_clr;
    logic              w_frame_done;
    logic              w_set_tmo;
    logic              w_set_ovf;
    logic              w_set_cmd;
    logic              w_clr_err;
    logic              w_accept;

    assign w_word        = bus.i_word;
    assign w_wordval     = bus.i_wordval;
    assign w_hdr_cmd     = hdr_cmd(w_word);
    assign w_hdr_len     = hdr_len(w_word);
    assign w_load_len_ok = (w_hdr_len != 12'd0) && (w_hdr_len <= 12'(NUM_TAPS));
    assign w_last        = (r_count == (r_len - 12'd1));
    assign w_pop         = r_sample_val && bus.i_sample_rdy;
    assign w_tmo_en      = (r_state != ST_IDLE);

    fir_ctrl_timeout #(
        .TIMEOUT_CLKS (TIMEOUT_CLKS)
    ) u_timeout (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .i_clr    (w_wordval),
        .i_en     (w_tmo_en),
        .o_expire (w_expire)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: words advance the frame, expiry falls back to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_wordval && (w_word == SYNC_WORD)) begin
                    w_state_nxt = ST_HDR;
                end
            end
            ST_HDR: begin
                if (w_wordval) begin
                    if ((w_hdr_cmd == CMD_LOAD) && w_load_len_ok) begin
                        w_state_nxt = ST_LOAD;
                    end else if ((w_hdr_cmd == CMD_STREAM) && (w_hdr_len != 12'd0)) begin
                        w_state_nxt = ST_STREAM;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_expire) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOAD, ST_STREAM: begin
                if (w_wordval && w_last) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_expire) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: strobes and flag updates that get registered next edge.
    always_comb begin
        w_coef_we    = 1'b0;
        w_fir_clr    = 1'b0;
        w_frame_done = 1'b0;
        w_set_tmo    = 1'b0;
        w_set_ovf    = 1'b0;
        w_set_cmd    = 1'b0;
        w_clr_err    = 1'b0;
        w_accept     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_clr_err = w_wordval && (w_word == SYNC_WORD);
            end
            ST_HDR: begin
                if (w_wordval) begin
                    case (w_hdr_cmd)
                        CMD_LOAD:   w_set_cmd = !w_load_len_ok;
                        CMD_STREAM: w_frame_done = (w_hdr_len == 12'd0);
                        CMD_CLEAR: begin
                            w_fir_clr    = 1'b1;
                            w_frame_done = 1'b1;
                        end
                        default:    w_set_cmd = 1'b1;
                    endcase
                end else begin
                    w_set_tmo = w_expire;
                end
            end
            ST_LOAD: begin
                if (w_wordval) begin
                    w_coef_we    = 1'b1;
                    w_frame_done = w_last;
                end else begin
                    w_set_tmo = w_expire;
                end
            end
            ST_STREAM: begin
                if (w_wordval) begin
                    w_accept     = !r_sample_val || w_pop;
                    w_set_ovf    = !w_accept;
                    // A drop on the final word also spoils this frame's completion.
                    w_frame_done = w_last && !r_ovf_frame && w_accept;
                end else begin
                    w_set_tmo = w_expire;
                end
            end
            default: ;
        endcase
    end

    // Registered strobes, coefficient port and sticky error flags.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_coef_we    <= 1'b0;
            r_coef_addr  <= '0;
            r_coef_data  <= '0;
            r_fir_clr    <= 1'b0;
            r_frame_done <= 1'b0;
            r_err_tmo    <= 1'b0;
            r_err_ovf    <= 1'b0;
            r_err_cmd    <= 1'b0;
        end else begin
            r_coef_we    <= w_coef_we;
            r_fir_clr    <= w_fir_clr;
            r_frame_done <= w_frame_done;
            if (w_coef_we) begin
                r_coef_addr <= r_count[ADDR_W-1:0];
                r_coef_data <= w_word;
            end
            if (w_clr_err) begin
                r_err_tmo <= 1'b0;
                r_err_ovf <= 1'b0;
                r_err_cmd <= 1'b0;
            end else begin
                if (w_set_tmo) r_err_tmo <= 1'b1;
                if (w_set_ovf) r_err_ovf <= 1'b1;
                if (w_set_cmd) r_err_cmd <= 1'b1;
            end
        end
    end

    // Frame length, word count and per-frame overflow tracking.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_count     <= '0;
            r_len       <= '0;
            r_ovf_frame <= 1'b0;
        end else if (w_wordval) begin
            if (r_state == ST_HDR) begin
                r_count     <= '0;
                r_len       <= w_hdr_len;
                r_ovf_frame <= 1'b0;
            end else if ((r_state == ST_LOAD) || (r_state == ST_STREAM)) begin
                r_count <= r_count + 12'd1;
                if (w_set_ovf) r_ovf_frame <= 1'b1;
            end
        end
    end

    // One-entry sample holding register; refill and drain may share an edge.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_sample     <= '0;
            r_sample_val <= 1'b0;
        end else if (w_accept) begin
            r_sample     <= w_word;
            r_sample_val <= 1'b1;
        end else if (w_pop) begin
            r_sample_val <= 1'b0;
        end
    end

    assign bus.o_coef_we    = r_coef_we;
    assign bus.o_coef_addr  = r_coef_addr;
    assign bus.o_coef_data  = r_coef_data;
    assign bus.o_sample     = r_sample;
    assign bus.o_sample_val = r_sample_val;
    assign o_fir_clr        = r_fir_clr;
    assign o_frame_done     = r_frame_done;
    assign o_busy           = (r_state != ST_IDLE) || r_sample_val;
    assign o_err_timeout    = r_err_tmo;
    assign o_err_overflow   = r_err_ovf;
    assign o_err_cmd        = r_err_cmd;
endmodule

// File: tb/tb_fir_uart_ctrl.sv
// Self-checking bench for fir_uart_ctrl: frame vector table plus hand-written
// backpressure, max-length, reset and timeout sequences; coefficient writes and
// delivered samples are checked against scoreboard queues.
module tb_fir_uart_ctrl;
    import fir_uart_pkg::*;

    localparam int unsigned NUM_TAPS = 16;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned TMO      = 40;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic fir_clr, frame_done, busy, err_tmo, err_ovf, err_cmd;

    always #5 clk = ~clk;

    fir_uart_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    fir_uart_ctrl #(
        .NUM_TAPS     (NUM_TAPS),
        .ADDR_W       (ADDR_W),
        .TIMEOUT_CLKS (TMO),
        .SYNC_WORD    (16'hA55A)
    ) dut (
        .i_clk          (clk),
        .i_rstn         (rstn),
        .bus            (bus),
        .o_fir_clr      (fir_clr),
        .o_frame_done   (frame_done),
        .o_busy         (busy),
        .o_err_timeout  (err_tmo),
        .o_err_overflow (err_ovf),
        .o_err_cmd      (err_cmd)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } coef_t;

    typedef struct {
        logic [15:0] hdr;
        int unsigned nd;
        logic [15:0] d [4];
        bit          exp_wr;
        bit          exp_smp;
        int unsigned exp_done;
        int unsigned exp_clr;
        bit          exp_cmd;
    } vec_t;

    coef_t       coef_q [$];
    logic [15:0] samp_q [$];
    vec_t        vecs [8];
    int unsigned total  = 0;
    int unsigned bad    = 0;
    int unsigned n_done = 0;
    int unsigned n_clr  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic [15:0] w);
        bus.i_word    = w;
        bus.i_wordval = 1'b1;
        @(posedge clk);
        #1;
        bus.i_wordval = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard monitor: pops expected writes/samples as the DUT produces them.
    always @(negedge clk) begin
        coef_t       ce;
        logic [15:0] se;
        if (rstn) begin
            if (bus.o_coef_we) begin
                if (coef_q.size() == 0) begin
                    chk("coef_unexpected", 32'd1, 32'd0);
                end else begin
                    ce = coef_q.pop_front();
                    chk("coef_addr", 32'(bus.o_coef_addr), 32'(ce.addr));
                    chk("coef_data", 32'(bus.o_coef_data), 32'(ce.data));
                end
            end
            if (bus.o_sample_val && bus.i_sample_rdy) begin
                if (samp_q.size() == 0) begin
                    chk("sample_unexpected", 32'(bus.o_sample), 32'hFFFF_FFFF);
                end else begin
                    se = samp_q.pop_front();
                    chk("sample_data", 32'(bus.o_sample), 32'(se));
                end
            end
            if (frame_done) n_done++;
            if (fir_clr)    n_clr++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned d0, c0;
        vecs[0] = '{16'h1004, 4, '{16'h0011, 16'h0022, 16'h0033, 16'h0044}, 1, 0, 1, 0, 0};
        vecs[1] = '{16'h7000, 0, '{16'h0, 16'h0, 16'h0, 16'h0}, 0, 0, 0, 0, 1};
        vecs[2] = '{16'h1011, 0, '{16'h0, 16'h0, 16'h0, 16'h0}, 0, 0, 0, 0, 1};
        vecs[3] = '{16'h3005, 0, '{16'h0, 16'h0, 16'h0, 16'h0}, 0, 0, 1, 1, 0};
        vecs[4] = '{16'h1000, 0, '{16'h0, 16'h0, 16'h0, 16'h0}, 0, 0, 0, 0, 1};
        vecs[5] = '{16'h2000, 0, '{16'h0, 16'h0, 16'h0, 16'h0}, 0, 0, 1, 0, 0};
        vecs[6] = '{16'h2003, 3, '{16'h0A01, 16'h0A02, 16'h0A03, 16'h0}, 0, 1, 1, 0, 0};
        vecs[7] = '{16'h1001, 1, '{16'hBEEF, 16'h0, 16'h0, 16'h0}, 1, 0, 1, 0, 0};

        bus.i_word       = '0;
        bus.i_wordval    = 1'b0;
        bus.i_sample_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_coef_we",    32'(bus.o_coef_we), 32'd0);
        chk("rst_coef_addr",  32'(bus.o_coef_addr), 32'd0);
        chk("rst_coef_data",  32'(bus.o_coef_data), 32'd0);
        chk("rst_sample",     32'(bus.o_sample), 32'd0);
        chk("rst_sample_val", 32'(bus.o_sample_val), 32'd0);
        chk("rst_flags", 32'({fir_clr, frame_done, busy, err_tmo, err_ovf, err_cmd}), 32'd0);
        rstn = 1'b1;
        idle(2);

        // Frame vector table; words within a frame are sent back-to-back.
        for (int v = 0; v < 8; v++) begin
            d0 = n_done;
            c0 = n_clr;
            send(16'hA55A);
            send(vecs[v].hdr);
            for (int i = 0; i < int'(vecs[v].nd); i++) begin
                if (vecs[v].exp_wr)  coef_q.push_back('{ADDR_W'(i), vecs[v].d[i]});
                if (vecs[v].exp_smp) samp_q.push_back(vecs[v].d[i]);
                send(vecs[v].d[i]);
            end
            idle(3);
            chk($sformatf("vec%0d_done", v), n_done - d0, vecs[v].exp_done);
            chk($sformatf("vec%0d_clr", v),  n_clr - c0,  vecs[v].exp_clr);
            chk($sformatf("vec%0d_err_cmd", v), 32'(err_cmd), 32'(vecs[v].exp_cmd));
            chk($sformatf("vec%0d_err_ovf", v), 32'(err_ovf), 32'd0);
            chk($sformatf("vec%0d_busy", v),    32'(busy), 32'd0);
        end

        // Maximum-length load fills every address.
        d0 = n_done;
        send(16'hA55A);
        send(16'h1010);
        for (int i = 0; i < int'(NUM_TAPS); i++) begin
            coef_q.push_back('{ADDR_W'(i), 16'(16'h1000 + i * 3)});
            send(16'(16'h1000 + i * 3));
        end
        idle(3);
        chk("maxload_done", n_done - d0, 32'd1);
        chk("maxload_err_cmd", 32'(err_cmd), 32'd0);
        chk("maxload_coef_q_empty", coef_q.size(), 32'd0);

        // Backpressure: first word held, the rest dropped, no completion.
        bus.i_sample_rdy = 1'b0;
        d0 = n_done;
        samp_q.push_back(16'h0100);
        send(16'hA55A);
        send(16'h2003);
        send(16'h0100);
        send(16'h0200);
        send(16'h0300);
        idle(3);
        chk("bp_sample_val", 32'(bus.o_sample_val), 32'd1);
        chk("bp_sample_hold", 32'(bus.o_sample), 32'h0100);
        chk("bp_err_ovf", 32'(err_ovf), 32'd1);
        chk("bp_no_done", n_done - d0, 32'd0);
        chk("bp_busy", 32'(busy), 32'd1);
        bus.i_sample_rdy = 1'b1;
        idle(3);
        chk("bp_drained", 32'(bus.o_sample_val), 32'd0);
        chk("bp_samp_q_empty", samp_q.size(), 32'd0);

        // Asynchronous reset mid-frame discards the pending sample.
        bus.i_sample_rdy = 1'b0;
        samp_q.push_back(16'h0777);
        send(16'hA55A);
        send(16'h2002);
        send(16'h0777);
        idle(2);
        chk("rst_mid_pending", 32'(bus.o_sample_val), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_mid_sample_val", 32'(bus.o_sample_val), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_err_ovf", 32'(err_ovf), 32'd0);
        samp_q.delete();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        bus.i_sample_rdy = 1'b1;
        idle(2);

        // Timeout inside a load: only the first coefficient lands.
        coef_q.push_back('{ADDR_W'(0), 16'h0011});
        send(16'hA55A);
        send(16'h1004);
        send(16'h0011);
        idle(TMO - 10);
        chk("tmo_not_early", 32'(err_tmo), 32'd0);
        chk("tmo_busy_early", 32'(busy), 32'd1);
        idle(20);
        chk("tmo_err", 32'(err_tmo), 32'd1);
        chk("tmo_idle", 32'(busy), 32'd0);
        d0 = n_done;
        c0 = n_clr;
        send(16'hA55A);
        send(16'h3000);
        idle(3);
        chk("tmo_clear_pulse", n_clr - c0, 32'd1);
        chk("tmo_clear_done", n_done - d0, 32'd1);
        chk("tmo_flag_cleared", 32'(err_tmo), 32'd0);

        chk("final_coef_q_empty", coef_q.size(), 32'd0);
        chk("final_samp_q_empty", samp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
